// File: rtl/signal_debounce.sv
// Per-bit debouncer with registered level output and single-cycle rise/fall strobes.
// Each bit runs an independent STABLE/PENDING filter advanced only on sample_en edges.
module signal_debounce #(
   parameter int unsigned      Width        = 1,
   parameter int unsigned      StableCycles = 4,
   parameter logic [Width-1:0] ResetValue   = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sample_en,
   input  logic [Width-1:0] sig_in,
   output logic [Width-1:0] sig_out,
   output logic [Width-1:0] rise,
   output logic [Width-1:0] fall
);

   localparam int unsigned CntW = (StableCycles > 1) ? $clog2(StableCycles + 1) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(StableCycles - 1);
   localparam logic [CntW-1:0] CntOne  = CntW'(1);
   localparam bit Immediate = (StableCycles <= 1);

   typedef enum logic {
      ST_STABLE,
      ST_PENDING
   } state_e;

   state_e          state_q [Width];
   state_e          state_d [Width];
   logic [CntW-1:0] cnt_q   [Width];
   logic [CntW-1:0] cnt_d   [Width];
   logic [Width-1:0] out_q, out_d;
   logic [Width-1:0] rise_q, rise_d;
   logic [Width-1:0] fall_q, fall_d;

   always_comb begin
      out_d  = out_q;
      rise_d = '0;
      fall_d = '0;
      for (int unsigned i = 0; i < Width; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
      end
      if (sample_en) begin
         for (int unsigned i = 0; i < Width; i++) begin
            case (state_q[i])
               ST_STABLE: begin
                  if (sig_in[i] != out_q[i]) begin
                     // A single required sample means the first differing sample is accepted.
                     if (Immediate) begin
                        out_d[i]  = sig_in[i];
                        rise_d[i] = sig_in[i];
                        fall_d[i] = ~sig_in[i];
                     end else begin
                        state_d[i] = ST_PENDING;
                        cnt_d[i]   = CntOne;
                     end
                  end else begin
                     cnt_d[i] = '0;
                  end
               end
               ST_PENDING: begin
                  if (sig_in[i] == out_q[i]) begin
                     state_d[i] = ST_STABLE;
                     cnt_d[i]   = '0;
                  end else if (cnt_q[i] == CntLast) begin
                     out_d[i]   = sig_in[i];
                     rise_d[i]  = sig_in[i];
                     fall_d[i]  = ~sig_in[i];
                     state_d[i] = ST_STABLE;
                     cnt_d[i]   = '0;
                  end else begin
                     cnt_d[i] = cnt_q[i] + CntOne;
                  end
               end
               default: begin
                  state_d[i] = ST_STABLE;
                  cnt_d[i]   = '0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < Width; i++) begin
            state_q[i] <= ST_STABLE;
            cnt_q[i]   <= '0;
         end
         out_q  <= ResetValue;
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         for (int unsigned i = 0; i < Width; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         out_q  <= out_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign sig_out = out_q;
   assign rise    = rise_q;
   assign fall    = fall_q;

endmodule

// File: tb/tb_signal_debounce.sv
// Scoreboard bench for signal_debounce: two instances (StableCycles 4 and 1) share stimulus,
// a sliding-window reference model predicts each edge's outputs.
module tb_signal_debounce;

   logic       clk;
   logic       rst_n;
   logic       sample_en;
   logic [1:0] sig_in;
   logic [1:0] o4, r4, f4;
   logic [1:0] o1, r1, f1;
   bit         clk_run = 1'b1;

   localparam logic [1:0] RV4 = 2'b00;
   localparam logic [1:0] RV1 = 2'b01;

   signal_debounce #(.Width(2), .StableCycles(4), .ResetValue(RV4)) dut4 (
      .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .sig_in(sig_in),
      .sig_out(o4), .rise(r4), .fall(f4)
   );

   signal_debounce #(.Width(2), .StableCycles(1), .ResetValue(RV1)) dut1 (
      .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .sig_in(sig_in),
      .sig_out(o1), .rise(r1), .fall(f1)
   );

   initial clk = 1'b0;
   always begin
      #5;
      if (clk_run) clk = ~clk;
   end

   typedef struct packed {
      logic [1:0] o4, r4, f4, o1, r1, f1;
   } exp_t;

   exp_t        sb[$];
   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   // Reference model: a level is accepted once the last N enabled samples all differ from it.
   int unsigned sc_of [2] = '{4, 1};
   logic [1:0]  rv_of [2] = '{RV4, RV1};
   logic [63:0] hist  [2][2];
   int unsigned nh    [2][2];
   logic [1:0]  mout  [2];
   logic [1:0]  mr    [2];
   logic [1:0]  mf    [2];

   task automatic model_edge(input logic r, input logic en, input logic [1:0] in);
      logic [63:0] mask;
      logic [63:0] want;
      for (int unsigned d = 0; d < 2; d++) begin
         for (int unsigned b = 0; b < 2; b++) begin
            mr[d][b] = 1'b0;
            mf[d][b] = 1'b0;
            if (!r) begin
               mout[d][b] = rv_of[d][b];
               hist[d][b] = '0;
               nh[d][b]   = 0;
            end else if (en) begin
               hist[d][b] = {hist[d][b][62:0], in[b]};
               if (nh[d][b] < 64) nh[d][b] = nh[d][b] + 1;
               mask = (64'd1 << sc_of[d]) - 64'd1;
               want = {64{~mout[d][b]}};
               if (nh[d][b] >= sc_of[d] && ((hist[d][b] ^ want) & mask) == 64'd0) begin
                  mout[d][b] = ~mout[d][b];
                  mr[d][b]   = mout[d][b];
                  mf[d][b]   = ~mout[d][b];
               end
            end
         end
      end
   endtask

   task automatic step(input logic r, input logic en, input logic [1:0] in);
      exp_t e;
      @(negedge clk);
      rst_n     = r;
      sample_en = en;
      sig_in    = in;
      model_edge(r, en, in);
      e.o4 = mout[0]; e.r4 = mr[0]; e.f4 = mf[0];
      e.o1 = mout[1]; e.r1 = mr[1]; e.f1 = mf[1];
      sb.push_back(e);
   endtask

   function automatic void chk(string nm, logic [1:0] act, logic [1:0] exp);
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endfunction

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            n_vec++;
            chk("sig_out_sc4", o4, e.o4);
            chk("rise_sc4", r4, e.r4);
            chk("fall_sc4", f4, e.f4);
            chk("sig_out_sc1", o1, e.o1);
            chk("rise_sc1", r1, e.r1);
            chk("fall_sc1", f1, e.f1);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at %0t, limit 1000000", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0] cur;
      logic       r, en;
      rst_n     = 1'b0;
      sample_en = 1'b0;
      sig_in    = 2'b00;

      repeat (3) step(1'b0, 1'b1, 2'b00);
      repeat (20) step(1'b1, 1'b1, 2'b00);

      // Clean step on bit0, then return low.
      repeat (8) step(1'b1, 1'b1, 2'b01);
      repeat (8) step(1'b1, 1'b1, 2'b00);

      // 3-high / 1-low glitches on bit0 never reach acceptance.
      for (int unsigned k = 0; k < 10; k++) begin
         repeat (3) step(1'b1, 1'b1, 2'b01);
         step(1'b1, 1'b1, 2'b00);
      end

      // Sampling every 3rd clock; low glitch on bit1 only during non-enabled cycles.
      for (int unsigned k = 0; k < 24; k++) begin
         step(1'b1, (k % 3) == 0, ((k % 3) == 1 && k < 12) ? 2'b00 : 2'b10);
      end

      // Both bits rise, then fall together.
      repeat (6) step(1'b1, 1'b1, 2'b11);
      repeat (6) step(1'b1, 1'b1, 2'b00);
      repeat (6) step(1'b1, 1'b1, 2'b11);

      // Asynchronous reset with the clock held low.
      @(negedge clk);
      clk_run = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      n_vec++;
      chk("async_sig_out_sc4", o4, RV4);
      chk("async_rise_sc4", r4, 2'b00);
      chk("async_fall_sc4", f4, 2'b00);
      chk("async_sig_out_sc1", o1, RV1);
      model_edge(1'b0, 1'b1, 2'b11);
      clk_run = 1'b1;
      repeat (2) step(1'b0, 1'b1, 2'b00);

      // Reset while bit0 is pending: the partial count is discarded.
      repeat (3) step(1'b1, 1'b1, 2'b00);
      repeat (2) step(1'b1, 1'b1, 2'b01);
      repeat (2) step(1'b0, 1'b1, 2'b01);
      repeat (6) step(1'b1, 1'b1, 2'b01);

      // Toggle every clock: StableCycles=1 follows, StableCycles=4 never does.
      for (int unsigned k = 0; k < 12; k++) step(1'b1, 1'b1, (k % 2) ? 2'b11 : 2'b00);

      cur = 2'b00;
      for (int unsigned k = 0; k < 2000; k++) begin
         if ($urandom_range(0, 5) == 0) cur[0] = ~cur[0];
         if ($urandom_range(0, 5) == 0) cur[1] = ~cur[1];
         r  = ($urandom_range(0, 199) != 0);
         en = ($urandom_range(0, 3) != 0);
         step(r, en, cur);
      end
      repeat (6) step(1'b1, 1'b1, cur);

      repeat (3) @(posedge clk);
      #2;
      n_vec++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
